// File: rtl/shabal_perm_ctrl.sv
// Sequences one Shabal keyed permutation P(M,A,B,C) around a single step datapath:
// 16*LOOPS mixing steps, FINAL_ADDS final A += C additions, then A/B out with a done pulse.
module shabal_perm_ctrl #(
    parameter int LOOPS      = 3,
    parameter int FINAL_ADDS = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [383:0] a_in,
    input  logic [511:0] b_in,
    input  logic [511:0] c_in,
    input  logic [511:0] m_in,
    output logic         busy,
    output logic         done,
    output logic [383:0] a_out,
    output logic [511:0] b_out
);

    localparam int RUN_STEPS = 16 * LOOPS;
    localparam int LAST_STEP = RUN_STEPS + FINAL_ADDS - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t      state_reg;
    logic [6:0]  cnt_reg;

    logic [31:0] ar_reg  [12];
    logic [31:0] br_reg  [16];
    logic [31:0] cr_reg  [16];
    logic [31:0] mr_reg  [16];
    logic [31:0] ar_next [12];
    logic [31:0] br_next [16];
    logic [31:0] cr_next [16];
    logic [31:0] mr_next [16];

    logic        load;
    logic        run_step;
    logic        fin_step;

    logic [31:0] a11_rot;
    logic [31:0] v_term;
    logic [31:0] u_in;
    logic [31:0] u_term;
    logic [31:0] a_step;
    logic [31:0] b_step;
    logic [31:0] a_final;

    logic [383:0] a_pack;
    logic [511:0] b_pack;

    assign load     = (state_reg == IDLE) && start;
    assign run_step = (state_reg == RUN);
    assign fin_step = (state_reg == FINAL);

    // Step datapath: the register windows already present the words the current step needs.
    assign a11_rot = {ar_reg[11][16:0], ar_reg[11][31:17]};
    assign v_term  = a11_rot + {a11_rot[29:0], 2'b00};
    assign u_in    = ar_reg[0] ^ v_term ^ cr_reg[8];
    assign u_term  = u_in + {u_in[30:0], 1'b0};
    assign a_step  = u_term ^ br_reg[13] ^ (br_reg[9] & ~br_reg[6]) ^ mr_reg[0];
    assign b_step  = ~{br_reg[0][30:0], br_reg[0][31]} ^ a_step;
    assign a_final = ar_reg[0] + cr_reg[3];

    genvar gi;

    generate
        for (gi = 0; gi < 12; gi++) begin : g_a
            if (gi == 11) begin : g_top
                assign ar_next[gi] = load     ? a_in[32*gi +: 32] :
                                     run_step ? a_step            :
                                     fin_step ? a_final           : ar_reg[gi];
            end else begin : g_mid
                assign ar_next[gi] = load                 ? a_in[32*gi +: 32] :
                                     (run_step | fin_step) ? ar_reg[gi+1]      : ar_reg[gi];
            end
            assign a_pack[32*gi +: 32] = ar_next[gi];
        end

        for (gi = 0; gi < 16; gi++) begin : g_bcm
            // B enters pre-rotated left by 17.
            if (gi == 15) begin : g_btop
                assign br_next[gi] = load     ? {b_in[32*gi+14 -: 15], b_in[32*gi+31 -: 17]} :
                                     run_step ? b_step : br_reg[gi];
                assign mr_next[gi] = load     ? m_in[32*gi +: 32] :
                                     run_step ? mr_reg[0] : mr_reg[gi];
            end else begin : g_bmid
                assign br_next[gi] = load     ? {b_in[32*gi+14 -: 15], b_in[32*gi+31 -: 17]} :
                                     run_step ? br_reg[gi+1] : br_reg[gi];
                assign mr_next[gi] = load     ? m_in[32*gi +: 32] :
                                     run_step ? mr_reg[gi+1] : mr_reg[gi];
            end
            // C rotates up while mixing and down during the final additions.
            assign cr_next[gi] = load     ? c_in[32*gi +: 32]          :
                                 run_step ? cr_reg[(gi + 15) % 16]     :
                                 fin_step ? cr_reg[(gi + 1) % 16]      : cr_reg[gi];
            assign b_pack[32*gi +: 32] = br_next[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 12; k++) begin
                ar_reg[k] <= '0;
            end
            for (int k = 0; k < 16; k++) begin
                br_reg[k] <= '0;
                cr_reg[k] <= '0;
                mr_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 12; k++) begin
                ar_reg[k] <= ar_next[k];
            end
            for (int k = 0; k < 16; k++) begin
                br_reg[k] <= br_next[k];
                cr_reg[k] <= cr_next[k];
                mr_reg[k] <= mr_next[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + 7'd1;
                    if (cnt_reg == 7'(RUN_STEPS - 1)) begin
                        state_reg <= FINAL;
                    end
                end
                FINAL: begin
                    // The last edge also performs the last addition, so capture the next-state words.
                    if (cnt_reg == 7'(LAST_STEP)) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        a_out     <= a_pack;
                        b_out     <= b_pack;
                    end else begin
                        cnt_reg <= cnt_reg + 7'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shabal_perm_ctrl.sv
// Scoreboard bench for shabal_perm_ctrl: a word-indexed reference of P(M,A,B,C)
// predicts each result at start time; a done monitor pops and compares.
module tb_shabal_perm_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [383:0] a_in;
    logic [511:0] b_in;
    logic [511:0] c_in;
    logic [511:0] m_in;
    logic         busy;
    logic         done;
    logic [383:0] a_out;
    logic [511:0] b_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [895:0] sb_q [$];

    shabal_perm_ctrl #(.LOOPS(3), .FINAL_ADDS(36)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .c_in  (c_in),
        .m_in  (m_in),
        .busy  (busy),
        .done  (done),
        .a_out (a_out),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [895:0] shabal_p(input logic [383:0] a, input logic [511:0] b,
                                              input logic [511:0] c, input logic [511:0] m);
        logic [31:0] aw [12];
        logic [31:0] bw [16];
        logic [31:0] cw [16];
        logic [31:0] mw [16];
        logic [31:0] t;
        logic [383:0] ao;
        logic [511:0] bo;
        int idx;
        int prv;
        for (int k = 0; k < 12; k++) aw[k] = a[32*k +: 32];
        for (int k = 0; k < 16; k++) begin
            bw[k] = rotl(b[32*k +: 32], 17);
            cw[k] = c[32*k +: 32];
            mw[k] = m[32*k +: 32];
        end
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 16; i++) begin
                idx = (i + 16*j) % 12;
                prv = (i + 16*j + 11) % 12;
                t = aw[idx] ^ (rotl(aw[prv], 15) * 32'd5) ^ cw[(24 - i) % 16];
                aw[idx] = (t * 32'd3) ^ bw[(i + 13) % 16] ^ (bw[(i + 9) % 16] & ~bw[(i + 6) % 16]) ^ mw[i];
                bw[i] = ~rotl(bw[i], 1) ^ aw[idx];
            end
        end
        for (int j = 0; j < 36; j++) begin
            aw[j % 12] = aw[j % 12] + cw[(j + 3) % 16];
        end
        for (int k = 0; k < 12; k++) ao[32*k +: 32] = aw[k];
        for (int k = 0; k < 16; k++) bo[32*k +: 32] = bw[k];
        return {ao, bo};
    endfunction

    task automatic rand_inputs();
        for (int k = 0; k < 12; k++) a_in[32*k +: 32] = $urandom;
        for (int k = 0; k < 16; k++) begin
            b_in[32*k +: 32] = $urandom;
            c_in[32*k +: 32] = $urandom;
            m_in[32*k +: 32] = $urandom;
        end
    endtask

    // Result monitor: every done pulse must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("sb_pending", 512'(sb_q.size()), 512'(1));
            end else begin
                logic [895:0] exp_v;
                exp_v = sb_q.pop_front();
                check("a_out", 512'(a_out), 512'(exp_v[895:512]));
                check("b_out", b_out, exp_v[511:0]);
            end
        end
    end

    task automatic do_run(input logic [383:0] a, input logic [511:0] b, input logic [511:0] c,
                          input logic [511:0] m, input bit scramble, input bit hold_start,
                          input string tag);
        int lat;
        int busy_n;
        bit got;
        @(posedge clk);
        #1;
        a_in  = a;
        b_in  = b;
        c_in  = c;
        m_in  = m;
        start = 1'b1;
        sb_q.push_back(shabal_p(a, b, c, m));
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        lat    = 0;
        busy_n = 0;
        got    = 1'b0;
        while (!got && lat < 200) begin
            if (scramble) rand_inputs();
            if (lat == 80) start = 1'b0;
            @(negedge clk);
            lat++;
            if (busy) busy_n++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, "_lat"}, 512'(lat), 512'(85));
        check({tag, "_busy"}, 512'(busy_n), 512'(84));
        @(negedge clk);
        check({tag, "_idle"}, 512'({busy, done}), 512'(0));
        $display("run %s latency=%0d busy_cycles=%0d", tag, lat, busy_n);
    endtask

    logic [511:0] m_iv;
    logic [383:0] ra;
    logic [511:0] rb, rc, rm;

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        rand_inputs();

        // Reset held with start high must leave everything cleared and idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_a", 512'(a_out), 512'(0));
        check("rst_b", b_out, 512'(0));
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_norun", 512'({busy, done}), 512'(0));

        // Timing with start held high through most of the run.
        rand_inputs();
        do_run(a_in, b_in, c_in, m_in, 1'b0, 1'b1, "timing");

        do_run('0, '0, '0, '0, 1'b0, 1'b0, "zero");
        for (int i = 0; i < 16; i++) m_iv[32*i +: 32] = 32'h100 + 32'(i);
        do_run('0, '0, '0, m_iv, 1'b0, 1'b0, "iv0");
        for (int i = 0; i < 16; i++) m_iv[32*i +: 32] = 32'h110 + 32'(i);
        do_run('0, '0, '0, m_iv, 1'b0, 1'b0, "iv1");

        // Inputs scrambled every cycle after the load edge.
        rand_inputs();
        do_run(a_in, b_in, c_in, m_in, 1'b1, 1'b0, "scramble");

        // Abort mid-run with reset: no done, outputs cleared, next run still correct.
        @(posedge clk);
        #1;
        rand_inputs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("abort_ctrl", 512'({busy, done}), 512'(0));
        check("abort_a", 512'(a_out), 512'(0));
        check("abort_b", b_out, 512'(0));
        repeat (4) @(negedge clk);
        check("abort_quiet", 512'({busy, done}), 512'(0));
        rand_inputs();
        do_run(a_in, b_in, c_in, m_in, 1'b0, 1'b0, "after_abort");

        // Back-to-back runs with start held high: a new load every 85 cycles.
        @(posedge clk);
        #1;
        rand_inputs();
        start = 1'b1;
        sb_q.push_back(shabal_p(a_in, b_in, c_in, m_in));
        for (int r = 0; r < 100; r++) begin
            int lat;
            bit got;
            @(posedge clk);
            #1;
            rand_inputs();
            lat = 0;
            got = 1'b0;
            while (!got && lat < 200) begin
                @(negedge clk);
                lat++;
                if (done) got = 1'b1;
            end
            check("b2b_period", 512'(lat), 512'(85));
            if (!got) break;
            $display("b2b run %0d period=%0d", r, lat);
            if (r < 99) begin
                ra = '0; rb = '0; rc = '0; rm = '0;
                for (int k = 0; k < 12; k++) ra[32*k +: 32] = $urandom;
                for (int k = 0; k < 16; k++) begin
                    rb[32*k +: 32] = $urandom;
                    rc[32*k +: 32] = $urandom;
                    rm[32*k +: 32] = $urandom;
                end
                a_in = ra; b_in = rb; c_in = rc; m_in = rm;
                sb_q.push_back(shabal_p(ra, rb, rc, rm));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_end", 512'({busy, done}), 512'(0));
        check("sb_drained", 512'(sb_q.size()), 512'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
